// File: rtl/pwm_ramp_sequencer.sv
// Wishbone write master that programs a pwm_timer and ramps its duty register in held steps.
// First strobe 1 cycle after start; each write holds adr/data until ack, then idles >=1 cycle.
module pwm_ramp_sequencer #(
  parameter int         HOLD_W      = 16,
  parameter int         ACK_TIMEOUT = 16,
  parameter logic [7:0] CTRL_RUN    = 8'h16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic [15:0]       i_divisor,
  input  logic [15:0]       i_period,
  input  logic [15:0]       i_dc_start,
  input  logic [15:0]       i_dc_end,
  input  logic [15:0]       i_dc_step,
  input  logic [HOLD_W-1:0] i_hold,
  output logic              o_wb_cyc,
  output logic              o_wb_stb,
  output logic              o_wb_we,
  output logic [3:0]        o_wb_adr,
  output logic [15:0]       o_wb_data,
  input  logic              i_wb_ack,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic [15:0]       o_dc_cur
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] WR_DIV  = 3'd1;
  localparam logic [2:0] WR_PER  = 3'd2;
  localparam logic [2:0] WR_DC   = 3'd3;
  localparam logic [2:0] WR_CTRL = 3'd4;
  localparam logic [2:0] HOLD    = 3'd5;
  localparam logic [2:0] WR_STOP = 3'd6;

  localparam int TO_W = $clog2(ACK_TIMEOUT + 1);

  logic [2:0]        state;
  logic [15:0]       divisor_q, period_q, dc_end_q, dc_step_q, dc_nxt;
  logic [HOLD_W-1:0] hold_q, hold_cnt;
  logic [TO_W-1:0]   to_cnt;
  logic              first_pass, abort_pend, abort_q;
  logic [3:0]        wr_adr;
  logic [15:0]       wr_dat, dc_calc, dc_diff;
  logic              dc_up;

  assign o_wb_stb = o_wb_cyc;
  assign o_wb_we  = o_wb_cyc;
  assign abort_q  = abort_pend | i_abort;

  // Next duty: step toward dc_end, clamping to dc_end when the remaining gap is within one step.
  always_comb begin
    dc_up   = dc_end_q > o_dc_cur;
    dc_diff = dc_up ? (dc_end_q - o_dc_cur) : (o_dc_cur - dc_end_q);
    dc_calc = dc_end_q;
    if (dc_step_q != 16'd0 && dc_diff > dc_step_q)
      dc_calc = dc_up ? (o_dc_cur + dc_step_q) : (o_dc_cur - dc_step_q);
  end

  always_comb begin
    wr_adr = 4'd0;
    wr_dat = 16'd0;
    case (state)
      WR_DIV:  begin wr_adr = 4'd1; wr_dat = divisor_q; end
      WR_PER:  begin wr_adr = 4'd2; wr_dat = period_q;  end
      WR_DC:   begin wr_adr = 4'd3; wr_dat = dc_nxt;    end
      WR_CTRL: begin wr_adr = 4'd0; wr_dat = {8'h00, CTRL_RUN}; end
      default: begin wr_adr = 4'd0; wr_dat = 16'd0;     end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= IDLE;
      divisor_q  <= '0;
      period_q   <= '0;
      dc_end_q   <= '0;
      dc_step_q  <= '0;
      dc_nxt     <= '0;
      hold_q     <= '0;
      hold_cnt   <= '0;
      to_cnt     <= '0;
      first_pass <= 1'b0;
      abort_pend <= 1'b0;
      o_wb_cyc   <= 1'b0;
      o_wb_adr   <= '0;
      o_wb_data  <= '0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_err      <= 1'b0;
      o_dc_cur   <= '0;
    end else begin
      o_done <= 1'b0;
      if (state != IDLE && state != WR_STOP && i_abort)
        abort_pend <= 1'b1;
      case (state)
        IDLE: begin
          if (i_start) begin
            divisor_q  <= i_divisor;
            period_q   <= i_period;
            dc_end_q   <= i_dc_end;
            dc_step_q  <= i_dc_step;
            dc_nxt     <= i_dc_start;
            hold_q     <= (i_hold == '0) ? HOLD_W'(1) : i_hold;
            first_pass <= 1'b1;
            abort_pend <= 1'b0;
            o_err      <= 1'b0;
            o_busy     <= 1'b1;
            o_wb_cyc   <= 1'b1;
            o_wb_adr   <= 4'd1;
            o_wb_data  <= i_divisor;
            to_cnt     <= '0;
            state      <= WR_DIV;
          end
        end
        HOLD: begin
          if (abort_q) begin
            state <= WR_STOP;
          end else if (hold_cnt == hold_q - HOLD_W'(1)) begin
            if (o_dc_cur == dc_end_q) begin
              state <= WR_STOP;
            end else begin
              dc_nxt <= dc_calc;
              state  <= WR_DC;
            end
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end
        WR_DIV, WR_PER, WR_DC, WR_CTRL, WR_STOP: begin
          if (!o_wb_cyc) begin
            // Idle gap cycle between transfers; an abort here skips straight to the stop write.
            if (abort_q && state != WR_STOP) begin
              state <= WR_STOP;
            end else begin
              o_wb_cyc  <= 1'b1;
              o_wb_adr  <= wr_adr;
              o_wb_data <= wr_dat;
              to_cnt    <= '0;
            end
          end else if (i_wb_ack) begin
            o_wb_cyc <= 1'b0;
            hold_cnt <= '0;
            if (state == WR_DC)
              o_dc_cur <= o_wb_data;
            if (state == WR_STOP) begin
              state  <= IDLE;
              o_busy <= 1'b0;
              o_done <= ~abort_pend;
            end else if (abort_q) begin
              state <= WR_STOP;
            end else if (state == WR_DIV) begin
              state <= WR_PER;
            end else if (state == WR_PER) begin
              state <= WR_DC;
            end else if (state == WR_DC) begin
              state <= first_pass ? WR_CTRL : HOLD;
            end else begin
              first_pass <= 1'b0;
              state      <= HOLD;
            end
          end else if (to_cnt == TO_W'(ACK_TIMEOUT - 1)) begin
            o_wb_cyc <= 1'b0;
            o_err    <= 1'b1;
            o_busy   <= 1'b0;
            state    <= IDLE;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_ramp_sequencer.sv
// Directed bench for pwm_ramp_sequencer: a registered-ack Wishbone slave model logs accepted writes.
module tb_pwm_ramp_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, abort = 1'b0;
  logic [15:0] divisor = '0, period = '0, dc_start = '0, dc_end = '0, dc_step = '0, hold = '0;
  logic        wb_cyc, wb_stb, wb_we, wb_ack;
  logic [3:0]  wb_adr;
  logic [15:0] wb_data, dc_cur;
  logic        busy, done, err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pwm_ramp_sequencer #(.HOLD_W(16), .ACK_TIMEOUT(16), .CTRL_RUN(8'h16)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_abort(abort),
    .i_divisor(divisor), .i_period(period), .i_dc_start(dc_start), .i_dc_end(dc_end),
    .i_dc_step(dc_step), .i_hold(hold),
    .o_wb_cyc(wb_cyc), .o_wb_stb(wb_stb), .o_wb_we(wb_we), .o_wb_adr(wb_adr),
    .o_wb_data(wb_data), .i_wb_ack(wb_ack),
    .o_busy(busy), .o_done(done), .o_err(err), .o_dc_cur(dc_cur)
  );

  // Slave: registered single-cycle ack after ack_delay extra strobe cycles.
  int ack_delay = 0;
  bit ack_never = 1'b0;
  int wait_cnt  = 0;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_ack   <= 1'b0;
      wait_cnt <= 0;
    end else if (wb_cyc && wb_stb && !wb_ack && !ack_never) begin
      if (wait_cnt >= ack_delay) begin
        wb_ack   <= 1'b1;
        wait_cnt <= 0;
      end else begin
        wait_cnt <= wait_cnt + 1;
      end
    end else begin
      wb_ack   <= 1'b0;
      wait_cnt <= 0;
    end
  end

  logic [3:0]  log_adr[$];
  logic [15:0] log_dat[$];
  int          log_cyc[$];
  logic [3:0]  exp_adr[$];
  logic [15:0] exp_dat[$];
  int cyc_n = 0, done_cnt = 0, proto_viol = 0, stb_run = 0, stb_run_last = 0;
  bit acc_prev = 1'b0, stb_prev = 1'b0;
  logic [3:0]  adr_prev = '0;
  logic [15:0] dat_prev = '0;
  logic [19:0] diff_got, diff_want;

  always @(negedge clk) begin
    cyc_n++;
    if (wb_cyc && wb_stb && wb_ack) begin
      log_adr.push_back(wb_adr);
      log_dat.push_back(wb_data);
      log_cyc.push_back(cyc_n);
    end
    if (acc_prev && wb_cyc) proto_viol++;
    if (wb_stb && (!wb_we || !wb_cyc)) proto_viol++;
    if (wb_stb && stb_prev && (wb_adr !== adr_prev || wb_data !== dat_prev)) proto_viol++;
    if (done) done_cnt++;
    if (wb_stb) stb_run++;
    else if (stb_run > 0) begin
      stb_run_last = stb_run;
      stb_run = 0;
    end
    acc_prev = wb_cyc && wb_stb && wb_ack;
    stb_prev = wb_stb;
    adr_prev = wb_adr;
    dat_prev = wb_data;
  end

  task automatic clear_mon();
    log_adr.delete(); log_dat.delete(); log_cyc.delete();
    exp_adr.delete(); exp_dat.delete();
    done_cnt = 0; proto_viol = 0;
  endtask

  task automatic exp_wr(input logic [3:0] a, input logic [15:0] d);
    exp_adr.push_back(a);
    exp_dat.push_back(d);
  endtask

  // Index of the first logged write differing from the expected list, or -1 when identical.
  function automatic int log_diff();
    int n;
    n = (log_adr.size() < exp_adr.size()) ? log_adr.size() : exp_adr.size();
    for (int i = 0; i < n; i++) begin
      if (log_adr[i] !== exp_adr[i] || log_dat[i] !== exp_dat[i]) begin
        diff_got  = {log_adr[i], log_dat[i]};
        diff_want = {exp_adr[i], exp_dat[i]};
        return i;
      end
    end
    if (log_adr.size() != exp_adr.size()) begin
      diff_got  = (n < log_adr.size()) ? {log_adr[n], log_dat[n]} : 20'hfffff;
      diff_want = (n < exp_adr.size()) ? {exp_adr[n], exp_dat[n]} : 20'hfffff;
      return n;
    end
    return -1;
  endfunction

  task automatic start_seq(input logic [15:0] dv, input logic [15:0] pr, input logic [15:0] s,
                           input logic [15:0] e, input logic [15:0] st, input logic [15:0] h);
    @(negedge clk);
    divisor = dv; period = pr; dc_start = s; dc_end = e; dc_step = st; hold = h;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({wb_cyc, wb_stb, wb_we} !== 3'b000) begin
      errors++; $display("FAIL reset_wb cyc/stb/we got %b want 000", {wb_cyc, wb_stb, wb_we});
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, done, err} !== 3'b000) begin
      errors++; $display("FAIL reset_status busy/done/err got %b want 000", {busy, done, err});
    end
    checks++;
    if (dc_cur !== 16'd0) begin
      errors++; $display("FAIL reset_dc_cur got %0d want 0", dc_cur);
    end
    checks++;
    if (wb_adr !== 4'd0 || wb_data !== 16'd0) begin
      errors++; $display("FAIL reset_adr_data got %0d/%0d want 0/0", wb_adr, wb_data);
    end
  endtask

  task automatic test_ramp_up();
    bit ok;
    int d;
    clear_mon();
    exp_wr(1, 1); exp_wr(2, 1000); exp_wr(3, 100); exp_wr(0, 16'h16);
    exp_wr(3, 200); exp_wr(3, 300); exp_wr(3, 400); exp_wr(0, 16'h0);
    start_seq(1, 1000, 100, 400, 100, 10);
    checks++;
    if ({wb_stb, busy, wb_adr} !== {1'b1, 1'b1, 4'd1}) begin
      errors++; $display("FAIL ramp_first_stb stb/busy/adr got %b/%b/%0d want 1/1/1", wb_stb, busy, wb_adr);
    end
    wait_idle(300, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL ramp_idle busy still %b want 0", busy); end
    d = log_diff();
    checks++;
    if (d != -1) begin
      errors++; $display("FAIL ramp_log idx %0d got adr/data %h want %h", d, diff_got, diff_want);
    end
    for (int i = 4; i < 7 && i < log_cyc.size(); i++) begin
      checks++;
      if (log_cyc[i] - log_cyc[i-1] < 12 || log_cyc[i] - log_cyc[i-1] > 14) begin
        errors++; $display("FAIL ramp_spacing write %0d gap %0d want 12..14", i, log_cyc[i] - log_cyc[i-1]);
      end
    end
    checks++;
    if (done_cnt !== 1 || err !== 1'b0) begin
      errors++; $display("FAIL ramp_done done_cnt/err got %0d/%b want 1/0", done_cnt, err);
    end
    checks++;
    if (dc_cur !== 16'd400) begin errors++; $display("FAIL ramp_dc_cur got %0d want 400", dc_cur); end
    checks++;
    if (proto_viol !== 0) begin errors++; $display("FAIL ramp_protocol got %0d violations want 0", proto_viol); end
  endtask

  task automatic test_clamp_down();
    bit ok;
    int d;
    clear_mon();
    exp_wr(1, 2); exp_wr(2, 600); exp_wr(3, 500); exp_wr(0, 16'h16);
    exp_wr(3, 300); exp_wr(3, 120); exp_wr(0, 16'h0);
    start_seq(2, 600, 500, 120, 200, 3);
    wait_idle(200, ok);
    d = log_diff();
    checks++;
    if (!ok || d != -1) begin
      errors++; $display("FAIL down_log ok=%b idx %0d got %h want %h", ok, d, diff_got, diff_want);
    end
    checks++;
    if (dc_cur !== 16'd120 || done_cnt !== 1) begin
      errors++; $display("FAIL down_end dc_cur/done got %0d/%0d want 120/1", dc_cur, done_cnt);
    end
    checks++;
    if (proto_viol !== 0) begin errors++; $display("FAIL down_protocol got %0d want 0", proto_viol); end
  endtask

  task automatic test_timeout();
    bit ok;
    clear_mon();
    ack_never = 1'b1;
    start_seq(1, 50, 10, 20, 5, 2);
    wait_idle(60, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL timeout_idle busy got %b want 0", busy); end
    checks++;
    if (stb_run_last !== 16) begin errors++; $display("FAIL timeout_stb_len got %0d want 16", stb_run_last); end
    checks++;
    if (err !== 1'b1 || done_cnt !== 0) begin
      errors++; $display("FAIL timeout_flags err/done got %b/%0d want 1/0", err, done_cnt);
    end
    checks++;
    if (log_adr.size() !== 0 || wb_cyc !== 1'b0) begin
      errors++; $display("FAIL timeout_writes got %0d writes cyc %b want 0/0", log_adr.size(), wb_cyc);
    end
    ack_never = 1'b0;
    clear_mon();
    start_seq(1, 50, 5, 5, 1, 1);
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL timeout_err_clear got %b want 0", err); end
    wait_idle(100, ok);
    checks++;
    if (!ok || done_cnt !== 1 || err !== 1'b0) begin
      errors++; $display("FAIL timeout_rerun ok/done/err got %b/%0d/%b want 1/1/0", ok, done_cnt, err);
    end
  endtask

  task automatic test_abort();
    bit ok, seen, held;
    int d;
    clear_mon();
    exp_wr(1, 1); exp_wr(2, 1000); exp_wr(3, 100); exp_wr(0, 16'h16); exp_wr(0, 16'h0);
    start_seq(1, 1000, 100, 400, 100, 20);
    ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      if (log_adr.size() >= 4) ok = 1'b1;
    end
    repeat (3) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (wb_stb && wb_adr == 4'd0) seen = 1'b1;
    end
    checks++;
    if (!ok || !seen) begin errors++; $display("FAIL abort_hold_stop reached/seen got %b/%b want 1/1", ok, seen); end
    wait_idle(100, ok);
    d = log_diff();
    checks++;
    if (!ok || d != -1) begin
      errors++; $display("FAIL abort_hold_log ok=%b idx %0d got %h want %h", ok, d, diff_got, diff_want);
    end
    checks++;
    if (done_cnt !== 0 || busy !== 1'b0 || dc_cur !== 16'd100) begin
      errors++; $display("FAIL abort_hold_end done/busy/dc got %0d/%b/%0d want 0/0/100", done_cnt, busy, dc_cur);
    end

    clear_mon();
    ack_delay = 5;
    exp_wr(1, 3); exp_wr(2, 700); exp_wr(0, 16'h0);
    start_seq(3, 700, 10, 40, 10, 4);
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (wb_stb && wb_adr == 4'd2) ok = 1'b1;
      else @(negedge clk);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    held = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (!wb_stb || wb_adr != 4'd2) held = 1'b0;
    end
    checks++;
    if (!ok || !held) begin errors++; $display("FAIL abort_stall_held reached/held got %b/%b want 1/1", ok, held); end
    wait_idle(100, ok);
    d = log_diff();
    checks++;
    if (!ok || d != -1) begin
      errors++; $display("FAIL abort_stall_log ok=%b idx %0d got %h want %h", ok, d, diff_got, diff_want);
    end
    checks++;
    if (done_cnt !== 0 || err !== 1'b0 || proto_viol !== 0) begin
      errors++; $display("FAIL abort_stall_end done/err/viol got %0d/%b/%0d want 0/0/0", done_cnt, err, proto_viol);
    end
    ack_delay = 0;
  endtask

  task automatic test_edges();
    bit ok;
    int d;
    clear_mon();
    exp_wr(1, 1); exp_wr(2, 100); exp_wr(3, 50); exp_wr(0, 16'h16); exp_wr(3, 900); exp_wr(0, 16'h0);
    start_seq(1, 100, 50, 900, 0, 2);
    repeat (3) @(negedge clk);
    divisor = 9; dc_end = 5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle(100, ok);
    d = log_diff();
    checks++;
    if (!ok || d != -1 || done_cnt !== 1) begin
      errors++; $display("FAIL step0_log ok=%b idx %0d got %h want %h done %0d", ok, d, diff_got, diff_want, done_cnt);
    end

    clear_mon();
    exp_wr(1, 2); exp_wr(2, 300); exp_wr(3, 77); exp_wr(0, 16'h16); exp_wr(0, 16'h0);
    start_seq(2, 300, 77, 77, 5, 0);
    wait_idle(100, ok);
    d = log_diff();
    checks++;
    if (!ok || d != -1 || done_cnt !== 1 || dc_cur !== 16'd77) begin
      errors++; $display("FAIL same_end_log ok=%b idx %0d got %h want %h done %0d dc %0d", ok, d, diff_got, diff_want, done_cnt, dc_cur);
    end

    ack_delay = 5;
    start_seq(3, 400, 20, 30, 5, 1);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (wb_stb) ok = 1'b1;
      else @(negedge clk);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (!ok || {wb_cyc, wb_stb, busy} !== 3'b000) begin
      errors++; $display("FAIL reset_mid_write cyc/stb/busy got %b want 000", {wb_cyc, wb_stb, busy});
    end
    @(negedge clk);
    rst = 1'b0;
    ack_delay = 0;
    @(negedge clk);
    clear_mon();
    exp_wr(1, 4); exp_wr(2, 800); exp_wr(3, 60); exp_wr(0, 16'h16); exp_wr(0, 16'h0);
    start_seq(4, 800, 60, 60, 1, 1);
    wait_idle(100, ok);
    d = log_diff();
    checks++;
    if (!ok || d != -1 || done_cnt !== 1) begin
      errors++; $display("FAIL after_reset_log ok=%b idx %0d got %h want %h done %0d", ok, d, diff_got, diff_want, done_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_ramp_up();
    test_clamp_down();
    test_timeout();
    test_abort();
    test_edges();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
